// File: rtl/key_circular_shift_core.sv
// Round-by-round circular shift of the two 32-bit halves (C, D) of a 64-bit key.
// Define KCS_ROTATE_RIGHT_EN to rotate right instead of left; timing is identical.
module key_circular_shift_core #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set,
  input  logic [0:63] key_in,
  output logic [0:63] key_out,
  output logic        status
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_t      state;
  logic [0:63] key_reg;
  logic [3:0]  round;

  function automatic logic [1:0] shift_amount(input logic [3:0] r);
    case (r)
      4'd0, 4'd1, 4'd8, 4'd15: return 2'd1;
      default:                 return 2'd2;
    endcase
  endfunction

  // Index 0 is the MSB, so numeric shifts match the bit-index rotation rule.
  function automatic logic [0:31] rotate(input logic [0:31] h, input logic [1:0] s);
`ifdef KCS_ROTATE_RIGHT_EN
    return (h >> s) | (h << (6'd32 - {4'b0, s}));
`else
    return (h << s) | (h >> (6'd32 - {4'b0, s}));
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_reg <= '0;
      round   <= '0;
      status  <= 1'b0;
    end else if (set) begin
      state   <= SHIFT;
      key_reg <= key_in;
      round   <= '0;
      status  <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          key_reg <= {rotate(key_reg[0:31], shift_amount(round)),
                      rotate(key_reg[32:63], shift_amount(round))};
          if (round == LAST_ROUND) begin
            state  <= DONE;
            status <= 1'b1;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign key_out = key_reg;

endmodule

// File: tb/tb_key_circular_shift_core.sv
// Directed/randomized bench for key_circular_shift_core; expected keys come from
// the cumulative shift total applied to each half with the index rotation rule.
module tb_key_circular_shift_core;

  logic        clk;
  logic        rst_n;
  logic        set;
  logic [0:63] key_in;
  logic [0:63] key_out;
  logic        status;

  int checks   = 0;
  int failures = 0;

  int unsigned sched [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  key_circular_shift_core #(.ROUNDS(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (set),
    .key_in  (key_in),
    .key_out (key_out),
    .status  (status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [0:31] rot_half(input logic [0:31] h, input int unsigned n);
    logic [0:31] r;
    for (int unsigned i = 0; i < 32; i++) begin
`ifdef KCS_ROTATE_RIGHT_EN
      r[i] = h[(i + 32 - (n % 32)) % 32];
`else
      r[i] = h[(i + n) % 32];
`endif
    end
    return r;
  endfunction

  // Expected key after k completed rounds.
  function automatic logic [0:63] model_key(input logic [0:63] k0, input int unsigned k);
    int unsigned total = 0;
    for (int unsigned j = 0; j < k; j++) total += sched[j];
    return {rot_half(k0[0:31], total), rot_half(k0[32:63], total)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [0:63] k);
    set    = 1'b1;
    key_in = k;
    step();
    set    = 1'b0;
    key_in = $urandom();
    chk("load_key", key_out, k);
    chk("load_status", {63'b0, status}, 64'd0);
  endtask

  task automatic run_rounds(input logic [0:63] k, input int unsigned first, input int unsigned last);
    for (int unsigned r = first; r <= last; r++) begin
      step();
      chk($sformatf("round%0d_key", r), key_out, model_key(k, r));
      chk($sformatf("round%0d_status", r), {63'b0, status}, {63'b0, (r == 16)});
    end
  endtask

  logic [0:63] k;

  initial begin
    rst_n  = 1'b0;
    set    = 1'b0;
    key_in = '0;
    #2;
    chk("reset_key", key_out, 64'd0);
    chk("reset_status", {63'b0, status}, 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // IDLE holds with set low
    for (int i = 0; i < 3; i++) begin
      key_in = {$urandom(), $urandom()};
      step();
      chk("idle_hold", key_out, 64'd0);
    end

    // Known vector, full run
    k = 64'h0123456789abcdef;
    load(k);
    step();
`ifdef KCS_ROTATE_RIGHT_EN
    chk("single_round_vec", key_out, 64'h8091a2b3c4d5e6f7);
`else
    chk("single_round_vec", key_out, 64'h02468ace13579bdf);
`endif
    run_rounds(k, 2, 16);
`ifdef KCS_ROTATE_RIGHT_EN
    chk("full_run_vec", key_out, 64'h123456709abcdef8);
`else
    chk("full_run_vec", key_out, 64'h70123456f89abcde);
`endif

    // DONE holds for 10 cycles
    for (int i = 0; i < 10; i++) begin
      key_in = {$urandom(), $urandom()};
      step();
      chk("done_hold_key", key_out, model_key(k, 16));
      chk("done_hold_status", {63'b0, status}, 64'd1);
    end

    // Random keys, full runs
    for (int t = 0; t < 3; t++) begin
      k = {$urandom(), $urandom()};
      load(k);
      run_rounds(k, 1, 16);
    end

    // Restart at round 5 (takes priority over rotation)
    k = {$urandom(), $urandom()};
    load(k);
    run_rounds(k, 1, 5);
    k = 64'hffffffff00000000;
    load(k);
    run_rounds(k, 1, 16);
    chk("restart_final", key_out, 64'hffffffff00000000);

    // Restart from DONE with a random key
    k = {$urandom(), $urandom()};
    load(k);
    run_rounds(k, 1, 16);

    // Asynchronous reset mid-SHIFT
    k = {$urandom(), $urandom()} | 64'h1;
    load(k);
    run_rounds(k, 1, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_key", key_out, 64'd0);
    chk("async_reset_status", {63'b0, status}, 64'd0);
    step();
    chk("reset_held_key", key_out, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_reset_idle_key", key_out, 64'd0);
      chk("post_reset_idle_status", {63'b0, status}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
